uart_rx_buffer: RTL and testbench

// - Downstream of the UART receiver. Captures each received byte (one-cycle rx_valid pulse) into a FIFO.
// - Exposes the FIFO to the CPU as memory-mapped DATA/STATUS/CTRL registers.
// - Provides a sticky overrun flag and a level interrupt, so software need not poll at the baud rate.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_buffer_if.sv | 34 +++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/uart_rx_buffer.sv | 110 +++++++++++
 tb/tb_uart_rx_buffer.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART register map: word offsets and the bit positions
//               of the STATUS / CTRL / DATA fields. Also used by the
//               transmit-side register block.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Register word offsets
    localparam logic [1:0] UART_RX_DATA   = 2'd0;
    localparam logic [1:0] UART_RX_STATUS = 2'd1;
    localparam logic [1:0] UART_RX_CTRL   = 2'd2;

    // DATA read: bit 8 flags that bits 7:0 carry a real byte
    localparam int DATA_VALID_BIT     = 8;

    // STATUS field positions
    localparam int STAT_NOT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT      = 1;
    localparam int STAT_OVERRUN_BIT   = 2;
    localparam int STAT_COUNT_LSB     = 8;

    // CTRL field positions
    localparam int CTRL_IE_BIT        = 0;
    localparam int CTRL_CLR_OVR_BIT   = 1;
    localparam int CTRL_FLUSH_BIT     = 2;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer_if
// Description : Receive-stream plus CPU bus bundle for uart_rx_buffer.
//               rx_data/rx_valid : byte strobe from the UART receiver
//               addr/re/we/wdata : register access from the CPU
//               rdata            : registered read data
//               irq              : level interrupt
//               slave  modport -> the buffer; master modport -> its driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_buffer_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [1:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport slave (
        input  rx_data, rx_valid, addr, re, we, wdata,
        output rdata, irq
    );

    modport master (
        output rx_data, rx_valid, addr, re, we, wdata,
        input  rdata, irq
    );

endinterface : uart_rx_buffer_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count and flush.
//               push/din  : write request and data
//               pop/dout  : read request; dout shows the head entry (FWFT)
//               flush     : empty the FIFO; dominates push and pop
//               count     : occupancy 0..DEPTH
//               full/empty: occupancy flags
//               A push while full is accepted only together with a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             flush,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic      [PTR_W:0]   count,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic w_push_ok;
    logic w_pop_ok;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign w_push_ok = push && (!full || pop) && !flush;
    assign w_pop_ok  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed after being written.
    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer
// Description : Buffers received UART bytes in a FIFO and exposes them as
//               DATA / STATUS / CTRL registers with a sticky overrun flag
//               and a level interrupt (ctrl_ie & !empty).
//               clk   : system clock
//               reset : synchronous active-high reset
//               bus   : uart_rx_buffer_if.slave (rx stream + CPU bus)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    uart_rx_buffer_if.slave   bus
);

    logic [7:0]     w_head;
    logic [PTR_W:0] w_count;
    logic           w_full;
    logic           w_empty;

    logic w_rd_data, w_wr_ctrl, w_flush, w_pop, w_push, w_ovr_set, w_ovr_clr;

    logic        overrun_q, overrun_d;
    logic        ie_q,      ie_d;
    logic [31:0] rdata_q,   rdata_d;

    // Only the low CTRL bits carry meaning.
    logic w_unused;
    assign w_unused = ^bus.wdata[31:3];

    assign w_rd_data = bus.re && (bus.addr == UART_RX_DATA);
    assign w_wr_ctrl = bus.we && (bus.addr == UART_RX_CTRL);
    assign w_flush   = w_wr_ctrl && bus.wdata[CTRL_FLUSH_BIT];
    assign w_ovr_clr = w_wr_ctrl && bus.wdata[CTRL_CLR_OVR_BIT];
    assign w_pop     = w_rd_data && !w_empty;
    assign w_push    = bus.rx_valid && !w_flush;
    // A flushed byte is discarded on purpose and does not count as overrun.
    assign w_ovr_set = bus.rx_valid && w_full && !w_pop && !w_flush;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (bus.rx_data),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        overrun_d = overrun_q;
        ie_d      = ie_q;
        rdata_d   = rdata_q;

        if (w_wr_ctrl) ie_d = bus.wdata[CTRL_IE_BIT];
        // Set is evaluated last so it wins over a same-cycle clear.
        if (w_ovr_clr) overrun_d = 1'b0;
        if (w_ovr_set) overrun_d = 1'b1;

        if (bus.re) begin
            rdata_d = '0;
            case (bus.addr)
                UART_RX_DATA: begin
                    if (!w_empty) begin
                        rdata_d[7:0]           = w_head;
                        rdata_d[DATA_VALID_BIT] = 1'b1;
                    end
                end
                UART_RX_STATUS: begin
                    rdata_d[STAT_COUNT_LSB +: 8]   = 8'(w_count);
                    rdata_d[STAT_OVERRUN_BIT]   = overrun_q;
                    rdata_d[STAT_FULL_BIT]      = w_full;
                    rdata_d[STAT_NOT_EMPTY_BIT] = !w_empty;
                end
                UART_RX_CTRL: rdata_d[CTRL_IE_BIT] = ie_q;
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
            ie_q      <= 1'b0;
            rdata_q   <= '0;
        end else begin
            overrun_q <= overrun_d;
            ie_q      <= ie_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.irq   = ie_q && !w_empty;

endmodule : uart_rx_buffer
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Directed self-checking bench for uart_rx_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_buffer_if u_if ();

    uart_rx_buffer #(.DEPTH(16)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (u_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus/rx cycle driven at a falling edge; strobes drop at the next
    // falling edge, by which time rdata has been updated.
    task automatic cyc(input logic [1:0] a, input logic r, input logic w,
                       input logic [31:0] wd, input logic rv, input logic [7:0] rd);
        @(negedge clk);
        u_if.addr = a; u_if.re = r; u_if.we = w; u_if.wdata = wd;
        u_if.rx_valid = rv; u_if.rx_data = rd;
        @(negedge clk);
        u_if.re = 1'b0; u_if.we = 1'b0; u_if.rx_valid = 1'b0; u_if.wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cyc(a, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00);
        d = u_if.rdata;
    endtask

    task automatic push(input logic [7:0] b);
        cyc(2'd0, 1'b0, 1'b0, 32'h0, 1'b1, b);
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        cyc(2'd2, 1'b0, 1'b1, v, 1'b0, 8'h00);
    endtask

    logic [31:0] d;

    initial begin
        u_if.addr = '0; u_if.re = 1'b0; u_if.we = 1'b0; u_if.wdata = '0;
        u_if.rx_valid = 1'b0; u_if.rx_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_rdata", u_if.rdata, 32'h0);
        check("reset_irq", {31'b0, u_if.irq}, 32'h0);
        rd(2'd1, d); check("reset_status", d, 32'h0);
        rd(2'd0, d); check("reset_data", d, 32'h0);
        rd(2'd2, d); check("reset_ctrl", d, 32'h0);
        rd(2'd3, d); check("reserved_read", d, 32'h0);

        // Single byte
        push(8'h41);
        rd(2'd1, d); check("status_one", d, 32'h0000_0101);
        rd(2'd0, d); check("data_41", d, 32'h0000_0141);
        rd(2'd1, d); check("status_after_pop", d, 32'h0);

        // Fill + overrun
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hAA);
        rd(2'd1, d); check("status_overrun", d, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            rd(2'd0, d); check($sformatf("drain_%0d", i), d, 32'h100 + i);
        end
        rd(2'd0, d); check("no_aa", d, 32'h0);
        rd(2'd1, d); check("status_empty_ovr", d, 32'h0000_0004);
        wr_ctrl(32'h2);
        rd(2'd1, d); check("ovr_cleared", d, 32'h0);

        // Full FIFO, push with simultaneous pop
        for (int i = 0; i < 16; i++) push(8'(i));
        cyc(2'd0, 1'b1, 1'b0, 32'h0, 1'b1, 8'h55);
        check("full_pushpop_data", u_if.rdata, 32'h0000_0100);
        rd(2'd1, d); check("full_pushpop_status", d, 32'h0000_1003);
        for (int i = 1; i < 16; i++) begin
            rd(2'd0, d); check($sformatf("drain2_%0d", i), d, 32'h100 + i);
        end
        rd(2'd0, d); check("last_55", d, 32'h0000_0155);

        // Push into empty with same-cycle DATA read: no bypass
        cyc(2'd0, 1'b1, 1'b0, 32'h0, 1'b1, 8'h5A);
        check("no_bypass", u_if.rdata, 32'h0);
        rd(2'd0, d); check("after_bypass", d, 32'h0000_015A);

        // Interrupt
        wr_ctrl(32'h1);
        check("irq_empty", {31'b0, u_if.irq}, 32'h0);
        rd(2'd2, d); check("ctrl_ie", d, 32'h1);
        push(8'h7E);
        check("irq_set", {31'b0, u_if.irq}, 32'h1);
        rd(2'd0, d); check("irq_data", d, 32'h0000_017E);
        check("irq_clear", {31'b0, u_if.irq}, 32'h0);

        // Flush with simultaneous rx_valid
        push(8'h01); push(8'h02); push(8'h03);
        rd(2'd1, d); check("three_stored", d, 32'h0000_0301);
        cyc(2'd2, 1'b0, 1'b1, 32'h4, 1'b1, 8'h33);
        rd(2'd1, d); check("flush_status", d, 32'h0);
        rd(2'd0, d); check("flush_data", d, 32'h0);

        // Reset mid-burst with overrun and ie set
        wr_ctrl(32'h1);
        for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
        rd(2'd1, d); check("pre_reset_status", d, 32'h0000_1007);
        @(negedge clk);
        rst = 1'b1; u_if.rx_valid = 1'b1; u_if.rx_data = 8'hEE;
        repeat (2) @(negedge clk);
        rst = 1'b0; u_if.rx_valid = 1'b0;
        check("mid_reset_rdata", u_if.rdata, 32'h0);
        check("mid_reset_irq", {31'b0, u_if.irq}, 32'h0);
        rd(2'd1, d); check("mid_reset_status", d, 32'h0);
        rd(2'd2, d); check("mid_reset_ctrl", d, 32'h0);
        rd(2'd0, d); check("mid_reset_data", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_buffer
`default_nettype wire
